// File: rtl/bram_arb_pkg.sv
// Shared definitions for the block-memory port arbiter and its users.
package bram_arb_pkg;

  // Default geometry of the 16384x12 single-port block memory.
  localparam int unsigned ARB_ADDR_W = 14;
  localparam int unsigned ARB_DATA_W = 12;
  localparam int unsigned ARB_DEPTH  = 16384;

  // Arbiter operating mode.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_e;

endpackage

// File: rtl/bram_rd_latency_pipe.sv
// Read-return pipe: delays the read grant by RD_LATENCY cycles and captures
// the memory output on the same edge that raises the tail valid bit.
module bram_rd_latency_pipe
  import bram_arb_pkg::*;
#(
  parameter int unsigned DATA_W     = ARB_DATA_W,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              gnt,
  input  logic [DATA_W-1:0] douta,
  output logic              rd_vld,
  output logic [DATA_W-1:0] rd_data
);

  logic [RD_LATENCY-1:0] vld_pipe;
  logic [RD_LATENCY:0]   stage;

  // Grant joins the bottom of the chain so every stage shifts uniformly.
  assign stage = {vld_pipe, gnt};

  // Shift valid bits and load read data when the next tail bit is set.
  always_ff @(posedge clka) begin
    if (rsta) begin
      vld_pipe <= '0;
      rd_data  <= '0;
    end else begin
      vld_pipe <= stage[RD_LATENCY-1:0];
      if (stage[RD_LATENCY-1]) begin
        rd_data <= douta;
      end
    end
  end

  assign rd_vld = vld_pipe[RD_LATENCY-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port block memory between a read requester, a write
// requester and a full-memory clear sequencer. Grants and memory pins are
// driven in the same cycle as the request; read data returns via a pipe.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned       ADDR_W        = ARB_ADDR_W,
  parameter int unsigned       DATA_W        = ARB_DATA_W,
  parameter int unsigned       DEPTH         = ARB_DEPTH,
  parameter int unsigned       RD_LATENCY    = 1,
  parameter int unsigned       MAX_RD_STREAK = 4,
  parameter logic [DATA_W-1:0] CLR_VALUE     = '0
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_vld,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              ram_ena,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_dina,
  input  logic [DATA_W-1:0] ram_douta
);

  localparam int unsigned        STREAK_W   = $clog2(MAX_RD_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_RD_STREAK);
  localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(DEPTH - 1);

  arb_state_e          state, state_nxt;
  logic [ADDR_W-1:0]   clr_addr, clr_addr_nxt;
  logic [STREAK_W-1:0] streak, streak_nxt;
  logic                clr_done_nxt;
  logic                write_wins;

  // State, clear pointer, streak counter and registered clear status.
  always_ff @(posedge clka) begin
    if (rsta) begin
      state    <= IDLE;
      clr_addr <= '0;
      streak   <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
      streak   <= streak_nxt;
      clr_busy <= (state_nxt == CLEAR);
      clr_done <= clr_done_nxt;
    end
  end

  // Write takes the port when alone or when reads have hit the streak limit.
  assign write_wins = wr_req && (!rd_req || (streak == STREAK_MAX));

  // Next state, arbitration and memory pin drive.
  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    streak_nxt   = streak;
    clr_done_nxt = 1'b0;
    rd_gnt       = 1'b0;
    wr_gnt       = 1'b0;
    ram_ena      = 1'b0;
    ram_wea      = 1'b0;
    ram_addra    = '0;
    ram_dina     = '0;

    if (!rsta) begin
      unique case (state)
        IDLE: begin
          if (write_wins) begin
            wr_gnt    = 1'b1;
            ram_ena   = 1'b1;
            ram_wea   = 1'b1;
            ram_addra = wr_addr;
            ram_dina  = wr_data;
          end else if (rd_req) begin
            rd_gnt    = 1'b1;
            ram_ena   = 1'b1;
            ram_addra = rd_addr;
          end

          // Streak only counts reads that overtook a waiting write.
          if (wr_gnt || !wr_req) begin
            streak_nxt = '0;
          end else if (rd_gnt && (streak != STREAK_MAX)) begin
            streak_nxt = streak + STREAK_W'(1);
          end

          // A grant issued in this cycle still completes; clear starts next.
          if (clr_start) begin
            state_nxt    = CLEAR;
            clr_addr_nxt = '0;
          end
        end

        CLEAR: begin
          ram_ena   = 1'b1;
          ram_wea   = 1'b1;
          ram_addra = clr_addr;
          ram_dina  = CLR_VALUE;
          if (clr_addr == LAST_ADDR) begin
            state_nxt    = IDLE;
            clr_addr_nxt = '0;
            clr_done_nxt = 1'b1;
          end else begin
            clr_addr_nxt = clr_addr + ADDR_W'(1);
          end
        end

        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Read data return path.
  bram_rd_latency_pipe #(
    .DATA_W     (DATA_W),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clka    (clka),
    .rsta    (rsta),
    .gnt     (rd_gnt),
    .douta   (ram_douta),
    .rd_vld  (rd_vld),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: two instances (read latency 1 and 3) share
// one stimulus stream and one memory image; a rule-level model predicts
// grants, memory pins, clear status and read returns every cycle.
module tb_bram_port_arbiter;
  import bram_arb_pkg::*;

  localparam int unsigned ADDR_W = ARB_ADDR_W;
  localparam int unsigned DATA_W = ARB_DATA_W;
  localparam int unsigned DEPTH  = ARB_DEPTH;
  localparam int unsigned MAXS   = 4;
  localparam int unsigned RING   = 8;
  localparam logic [DATA_W-1:0] CLR = '0;

  logic              clka;
  logic              rsta;
  logic              rd_req, wr_req, clr_start;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              rd_gnt1, rd_vld1, wr_gnt1, clr_busy1, clr_done1, ram_ena1, ram_wea1;
  logic [DATA_W-1:0] rd_data1, ram_dina1, ram_douta1;
  logic [ADDR_W-1:0] ram_addra1;
  logic              rd_gnt3, rd_vld3, wr_gnt3, clr_busy3, clr_done3, ram_ena3, ram_wea3;
  logic [DATA_W-1:0] rd_data3, ram_dina3, ram_douta3;
  logic [ADDR_W-1:0] ram_addra3;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [DATA_W-1:0] d3a, d3b;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  bram_port_arbiter #(.RD_LATENCY(1), .MAX_RD_STREAK(MAXS), .CLR_VALUE(CLR)) u_dut1 (
    .clka(clka), .rsta(rsta), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt1),
    .rd_vld(rd_vld1), .rd_data(rd_data1), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_gnt(wr_gnt1), .clr_start(clr_start), .clr_busy(clr_busy1),
    .clr_done(clr_done1), .ram_ena(ram_ena1), .ram_wea(ram_wea1), .ram_addra(ram_addra1),
    .ram_dina(ram_dina1), .ram_douta(ram_douta1));

  bram_port_arbiter #(.RD_LATENCY(3), .MAX_RD_STREAK(MAXS), .CLR_VALUE(CLR)) u_dut3 (
    .clka(clka), .rsta(rsta), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt3),
    .rd_vld(rd_vld3), .rd_data(rd_data3), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_gnt(wr_gnt3), .clr_start(clr_start), .clr_busy(clr_busy3),
    .clr_done(clr_done3), .ram_ena(ram_ena3), .ram_wea(ram_wea3), .ram_addra(ram_addra3),
    .ram_dina(ram_dina3), .ram_douta(ram_douta3));

  initial clka = 1'b0;
  always #5 clka = ~clka;

  // Memory: writes from the latency-1 instance; reads are sampled by each
  // instance on the RD_LATENCY-th edge after its grant.
  always @(posedge clka) begin
    if (ram_ena1 && ram_wea1) mem[ram_addra1] <= ram_dina1;
    d3a <= mem[ram_addra3];
    d3b <= d3a;
  end
  assign ram_douta1 = mem[ram_addra1];
  assign ram_douta3 = d3b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  bit                m_known = 1'b0;
  bit                m_busy  = 1'b0;
  bit                m_done  = 1'b0;
  int                m_idx   = 0;
  int                m_streak = 0;
  int unsigned       cyc = 0;
  bit                due1_v [RING];
  bit                due3_v [RING];
  logic [DATA_W-1:0] due1_d [RING];
  logic [DATA_W-1:0] due3_d [RING];

  always @(negedge clka) begin : compare
    logic e_rg, e_wg, e_ena, e_wea;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_din;
    int slot;
    slot  = int'(cyc % RING);
    e_rg  = 1'b0; e_wg = 1'b0; e_ena = 1'b0; e_wea = 1'b0;
    e_addr = '0;  e_din = '0;
    if (!rsta) begin
      if (m_busy) begin
        e_ena = 1'b1; e_wea = 1'b1; e_addr = ADDR_W'(m_idx); e_din = CLR;
      end else if (wr_req && (!rd_req || m_streak == MAXS)) begin
        e_wg = 1'b1; e_ena = 1'b1; e_wea = 1'b1; e_addr = wr_addr; e_din = wr_data;
      end else if (rd_req) begin
        e_rg = 1'b1; e_ena = 1'b1; e_addr = rd_addr;
      end
    end
    chk("rd_gnt", 32'(rd_gnt1), 32'(e_rg));
    chk("wr_gnt", 32'(wr_gnt1), 32'(e_wg));
    chk("ram_ena", 32'(ram_ena1), 32'(e_ena));
    chk("ram_wea", 32'(ram_wea1), 32'(e_wea));
    chk("rd_gnt_l3", 32'(rd_gnt3), 32'(e_rg));
    chk("wr_gnt_l3", 32'(wr_gnt3), 32'(e_wg));
    if (!rsta) chk("ram_addra", 32'(ram_addra1), 32'(e_addr));
    if (!rsta && (e_wea || !e_ena)) chk("ram_dina", 32'(ram_dina1), 32'(e_din));
    if (m_known) begin
      chk("clr_busy", 32'(clr_busy1), 32'(m_busy));
      chk("clr_busy_l3", 32'(clr_busy3), 32'(m_busy));
      chk("clr_done", 32'(clr_done1), 32'(m_done));
      chk("rd_vld_l1", 32'(rd_vld1), 32'(due1_v[slot]));
      chk("rd_vld_l3", 32'(rd_vld3), 32'(due3_v[slot]));
      if (due1_v[slot]) chk("rd_data_l1", 32'(rd_data1), 32'(due1_d[slot]));
      if (due3_v[slot]) chk("rd_data_l3", 32'(rd_data3), 32'(due3_d[slot]));
    end
    due1_v[slot] = 1'b0;
    due3_v[slot] = 1'b0;

    // Advance the model to the next cycle.
    if (rsta) begin
      m_known = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_idx = 0; m_streak = 0;
      for (int i = 0; i < int'(RING); i++) begin
        due1_v[i] = 1'b0;
        due3_v[i] = 1'b0;
      end
    end else begin
      if (e_rg) begin
        due1_v[(cyc + 1) % RING] = 1'b1;
        due1_d[(cyc + 1) % RING] = model_mem[rd_addr];
        due3_v[(cyc + 3) % RING] = 1'b1;
        due3_d[(cyc + 3) % RING] = model_mem[rd_addr];
      end
      if (m_busy) begin
        model_mem[m_idx] = CLR;
        if (m_idx == int'(DEPTH) - 1) begin
          m_busy = 1'b0; m_idx = 0; m_done = 1'b1;
        end else begin
          m_idx++; m_done = 1'b0;
        end
      end else begin
        m_done = 1'b0;
        if (e_wg) model_mem[wr_addr] = wr_data;
        if (e_wg || !wr_req) m_streak = 0;
        else if (e_rg) m_streak++;
        if (clr_start) begin
          m_busy = 1'b1; m_idx = 0;
        end
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  // Random requests that stay asserted with stable payload until granted.
  task automatic rand_traffic(input int n, input int lo, input int hi);
    logic g_r, g_w;
    for (int i = 0; i < n; i++) begin
      @(negedge clka);
      g_r = rd_gnt1;
      g_w = wr_gnt1;
      tick();
      if (!rd_req || g_r) begin
        rd_req  = ($urandom_range(3, 0) != 0);
        rd_addr = ADDR_W'($urandom_range(hi, lo));
      end
      if (!wr_req || g_w) begin
        wr_req  = ($urandom_range(2, 0) == 0);
        wr_addr = ADDR_W'($urandom_range(hi, lo));
        wr_data = DATA_W'($urandom);
      end
    end
  endtask

  logic [9:0] pat;
  logic [4:0] pat5;
  int busy_len, done_n, gnt_busy, fall_i, first_g;

  initial begin
    for (int a = 0; a < int'(DEPTH); a++) begin
      mem[a]       = DATA_W'(a) ^ 12'h5A5;
      model_mem[a] = DATA_W'(a) ^ 12'h5A5;
    end
    rsta = 1'b1; rd_req = 1'b0; wr_req = 1'b0; clr_start = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;

    // Reset: grants suppressed even with both requests up.
    tick(); rd_req = 1'b1; wr_req = 1'b1;
    #3 chk("reset rd_gnt", 32'(rd_gnt1), 32'd0);
    chk("reset wr_gnt", 32'(wr_gnt1), 32'd0);
    chk("reset ram_ena", 32'(ram_ena1), 32'd0);
    tick(); rsta = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    #3 chk("reset clr_busy", 32'(clr_busy1), 32'd0);
    chk("reset clr_done", 32'(clr_done1), 32'd0);
    chk("reset rd_vld", 32'(rd_vld1), 32'd0);
    chk("reset rd_data", 32'(rd_data1), 32'd0);
    chk("reset rd_data_l3", 32'(rd_data3), 32'd0);

    // Reads of 0,1,2 back to back.
    tick(); rd_req = 1'b1; rd_addr = 14'd0;
    #3 chk("read0 gnt", 32'(rd_gnt1), 32'd1);
    tick(); rd_addr = 14'd1;
    #3 chk("read0 vld", 32'(rd_vld1), 32'd1);
    chk("read0 data", 32'(rd_data1), 32'h5A5);
    tick(); rd_addr = 14'd2;
    #3 chk("read1 data", 32'(rd_data1), 32'h5A4);
    tick(); rd_req = 1'b0;
    #3 chk("read2 data", 32'(rd_data1), 32'h5A7);
    tick();
    #3 chk("read idle vld", 32'(rd_vld1), 32'd0);

    // Write then read back.
    tick(); wr_req = 1'b1; wr_addr = 14'h0100; wr_data = 12'hABC;
    #3 chk("write gnt", 32'(wr_gnt1), 32'd1);
    tick(); wr_req = 1'b0; rd_req = 1'b1; rd_addr = 14'h0100;
    #3 chk("readback gnt", 32'(rd_gnt1), 32'd1);
    tick(); rd_req = 1'b0;
    #3 chk("readback data", 32'(rd_data1), 32'hABC);

    // Starvation guard: both held.
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      tick(); rd_req = 1'b1; wr_req = 1'b1; rd_addr = 14'h0010; wr_addr = 14'h0020;
      wr_data = 12'h111;
      #3 pat = {pat[8:0], rd_gnt1};
    end
    chk("starve pattern", 32'(pat), 32'(10'b1111011110));
    for (int i = 0; i < 2; i++) tick();
    tick(); wr_req = 1'b0;
    tick(); wr_req = 1'b1;
    pat5 = '0;
    for (int i = 0; i < 5; i++) begin
      #3 pat5 = {pat5[3:0], rd_gnt1};
      tick();
    end
    chk("streak reset pattern", 32'(pat5), 32'(5'b11110));
    rd_req = 1'b0; wr_req = 1'b0;

    rand_traffic(400, 0, 63);
    tick(); rd_req = 1'b0; wr_req = 1'b0;

    // Back-to-back reads across clr_start, requests held through the clear.
    tick(); rd_req = 1'b1; rd_addr = 14'd5;
    tick(); rd_addr = 14'd6;
    tick(); rd_addr = 14'd7; clr_start = 1'b1;
    tick(); clr_start = 1'b0; rd_addr = 14'd8;
    wr_req = 1'b1; wr_addr = 14'h3FFF; wr_data = 12'h123;
    busy_len = 0; done_n = 0; gnt_busy = 0; fall_i = -1; first_g = -1;
    for (int i = 0; i < 16400; i++) begin
      #3;
      if (clr_busy1) busy_len++;
      if (clr_done1) done_n++;
      if (clr_busy1 && (rd_gnt1 || wr_gnt1)) gnt_busy++;
      if (!clr_busy1 && fall_i < 0) fall_i = i;
      if (!clr_busy1 && first_g < 0 && (rd_gnt1 || wr_gnt1)) first_g = i;
      tick();
      clr_start = (i == 100);
    end
    chk("clear busy length", 32'(busy_len), 32'd16384);
    chk("clear done pulses", 32'(done_n), 32'd1);
    chk("grants while busy", 32'(gnt_busy), 32'd0);
    chk("first grant after clear", 32'(first_g), 32'(fall_i));
    rd_req = 1'b0; wr_req = 1'b0;

    // Reads after clear return the clear value.
    for (int k = 0; k < 6; k++) begin
      tick(); rd_req = 1'b1; rd_addr = ADDR_W'($urandom_range(4000, 100));
      tick(); rd_req = 1'b0;
      #3 chk("post-clear vld", 32'(rd_vld1), 32'd1);
      chk("post-clear data", 32'(rd_data1), 32'h000);
    end

    // Reset in the middle of a clear.
    tick(); clr_start = 1'b1; rd_req = 1'b1; rd_addr = 14'd9;
    tick(); clr_start = 1'b0;
    for (int i = 0; i < 5000; i++) tick();
    chk("clear addr before reset", 32'(ram_addra1), 32'd5000);
    rsta = 1'b1;
    #3 chk("mid-clear reset ena", 32'(ram_ena1), 32'd0);
    chk("mid-clear reset rd_gnt", 32'(rd_gnt1), 32'd0);
    chk("mid-clear reset wr_gnt", 32'(wr_gnt1), 32'd0);
    tick(); rsta = 1'b0;
    #3 chk("after reset clr_busy", 32'(clr_busy1), 32'd0);
    chk("after reset clr_done", 32'(clr_done1), 32'd0);
    tick(); rd_req = 1'b0;

    // Traffic around the partially cleared boundary.
    rand_traffic(150, 4990, 5010);
    tick(); rd_req = 1'b0; wr_req = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares the single-port 16384x12 block memory between two requesters:
  - a read requester (pixel/display fetch);
  - a write requester (frame update).
- Also provides a built-in clear sequencer that fills the whole memory with a constant.
- Sits directly in front of the block memory instance and is the only driver of its ena/wea/addra/dina pins.

Parameters:
- ADDR_W, 14, memory address width.
- DATA_W, 12, memory data width.
- DEPTH, 16384, number of words; clear sweeps addresses 0..DEPTH-1.
- RD_LATENCY, 1, cycles from ram_ena (read) to valid ram_douta; legal range 1..3.
- MAX_RD_STREAK, 4, maximum consecutive read grants while a write is pending.
- CLR_VALUE, 12'h000, word written by the clear sequencer.

Ports:
- clka  in  1  system clock; also the clock of the block memory.
- rsta  in  1  synchronous reset, active-high.
- rd_req  in  1  read request; held with rd_addr until rd_gnt.
- rd_addr  in  ADDR_W  read address.
- rd_gnt  out  1  read accepted this cycle.
- rd_vld  out  1  rd_data valid.
- rd_data  out  DATA_W  read data.
- wr_req  in  1  write request; held with wr_addr/wr_data until wr_gnt.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_gnt  out  1  write accepted this cycle.
- clr_start  in  1  single-cycle pulse that starts a full-memory clear.
- clr_busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse after the last clear write.
- ram_ena  out  1  to memory ena.
- ram_wea  out  1  to memory wea.
- ram_addra  out  ADDR_W  to memory addra.
- ram_dina  out  DATA_W  to memory dina.
- ram_douta  in  DATA_W  from memory douta.

Behaviour:
- Clock and reset: one clock, clka. rsta is synchronous and active-high.
- Reset values:
  - state IDLE, streak=0, clr_addr=0, latency pipe all 0;
  - clr_busy=0, clr_done=0, rd_vld=0, rd_data=0.
  - rd_gnt, wr_gnt, ram_ena, ram_wea are 0 while rsta=1.
- Grant and memory drive path:
  - Grants and ram_* are combinational from the current state and requests (same-cycle access).
  - rd_vld/rd_data are registered.
- FSM states: IDLE, CLEAR.
- IDLE arbitration, per cycle:
  - Only rd_req: rd_gnt=1, ram_ena=1, ram_wea=0, ram_addra=rd_addr.
  - Only wr_req: wr_gnt=1, ram_ena=1, ram_wea=1, ram_addra=wr_addr, ram_dina=wr_data.
  - Both requests: read wins unless streak==MAX_RD_STREAK, in which case write wins.
  - Neither: ram_ena=0, ram_wea=0. ram_addra and ram_dina hold 0.
  - At most one grant per cycle; rd_gnt and wr_gnt are never both 1.
- Streak counter:
  - Increments on each rd_gnt while wr_req=1.
  - Clears on wr_gnt, or on any cycle with wr_req=0.
  - Never exceeds MAX_RD_STREAK.
- Read return:
  - A 1-bit valid pipe of depth RD_LATENCY is fed by rd_gnt.
  - rd_vld=1 and rd_data=ram_douta exactly RD_LATENCY cycles after rd_gnt.
  - Back-to-back grants give back-to-back rd_vld.
- Entering CLEAR: clr_start=1 in IDLE moves to CLEAR next cycle, with clr_addr=0 and clr_busy=1.
  - clr_start has priority over arbitration only from the next cycle; a grant in the same cycle still completes.
- CLEAR:
  - Each cycle: ram_ena=1, ram_wea=1, ram_addra=clr_addr, ram_dina=CLR_VALUE, clr_addr+1.
  - rd_gnt=0 and wr_gnt=0; requests stay pending, no data is lost.
  - streak holds.
  - Reads granted before CLEAR still return their rd_vld on schedule.
- Exiting CLEAR:
  - After writing DEPTH-1 (clr_addr wraps to 0), return to IDLE.
  - clr_busy=0 and clr_done=1 for exactly one cycle, on the first IDLE cycle.
  - A full clear takes exactly DEPTH cycles.
- clr_start while already in CLEAR: ignored; no restart.
- rsta mid-clear: immediate return to the reset values above; the memory is left partially cleared.
- Address arithmetic: all unsigned ADDR_W; no bounds check on requester addresses.

Decomposition:
- Shared package bram_arb_pkg holds:
  - the FSM state typedef (IDLE, CLEAR);
  - ADDR_W/DATA_W/DEPTH defaults, so the memory instance and its users agree.
- One sub-module: bram_rd_latency_pipe. It is a RD_LATENCY-deep valid shift register, with the rd_data capture at its tail.

Test Plan:
- Reads only: rd_req=1 with rd_addr 0,1,2 over 3 cycles (RD_LATENCY=1) -> rd_gnt 1,1,1; rd_vld=1 in cycles 2..4 with rd_data equal to memory contents at 0,1,2.
- Write then readback: wr_req with addr 14'h0100, data 12'hABC -> wr_gnt in the same cycle. A following read of 14'h0100 returns 12'hABC one cycle after rd_gnt.
- Starvation guard: rd_req and wr_req both held, MAX_RD_STREAK=4 -> grant pattern R,R,R,R,W,R,R,R,R,W…
  - Also check that dropping wr_req for one cycle resets the streak.
- Clear: pulse clr_start -> clr_busy=1 for exactly 16384 cycles, one write per cycle to addresses 0..16383; clr_done pulses once.
  - Requests made meanwhile see no grant until the cycle after clr_busy falls.
  - Random reads afterwards return 12'h000.
- Boundaries:
  - clr_start while busy -> no restart; total busy length stays 16384.
  - rsta asserted at clear address 5000 -> next cycle clr_busy=0, no clr_done, all grants 0.
- Latency sweep: RD_LATENCY=3 with back-to-back reads -> rd_vld exactly 3 cycles after each rd_gnt, including across a clr_start.
